// File: rtl/riscv_hwloop_pkg.sv
// Shared constants for the RI5CY hardware-loop register file.
// Holds the write-enable bit positions and the set-index width helper.
package riscv_hwloop_pkg;

  localparam int HWLP_WE_START    = 0;
  localparam int HWLP_WE_END      = 1;
  localparam int HWLP_WE_CNT      = 2;
  localparam int HWLP_MAX_REGSETS = 4;

  // Set index width is clog2(n), but never narrower than one bit.
  function automatic int regset_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/riscv_hwloop_regset.sv
// One hardware-loop set: start/end/counter registers plus the in-flight
// decrement bit that bridges controller issue (IF) and commit (ID).
module riscv_hwloop_regset (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_we_start,
  input  logic        i_we_end,
  input  logic        i_we_cnt,
  input  logic [31:0] i_start_data,
  input  logic [31:0] i_end_data,
  input  logic [31:0] i_cnt_data,
  input  logic        i_dec_issue,
  input  logic        i_id_valid,
  input  logic        i_flush,
  output logic [31:0] o_start,
  output logic [31:0] o_end,
  output logic [31:0] o_cnt,
  output logic        o_pending,
  output logic        o_active
);

  logic [31:0] r_start;
  logic [31:0] r_end;
  logic [31:0] r_cnt;
  logic        r_pending;
  logic        w_commit;

  // A flush kills the in-flight decrement before it can retire.
  assign w_commit = r_pending && i_id_valid && !i_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_start   <= '0;
      r_end     <= '0;
      r_cnt     <= '0;
      r_pending <= 1'b0;
    end else begin
      if (i_we_start) r_start <= i_start_data;
      if (i_we_end)   r_end   <= i_end_data;

      // Explicit write beats the decrement; a zero counter never wraps.
      if (i_we_cnt)
        r_cnt <= i_cnt_data;
      else if (w_commit && (r_cnt != 32'd0))
        r_cnt <= r_cnt - 32'd1;

      if (i_flush)
        r_pending <= 1'b0;
      else if (i_dec_issue)
        r_pending <= 1'b1;
      else if (w_commit)
        r_pending <= 1'b0;
    end
  end

  assign o_start   = r_start;
  assign o_end     = r_end;
  assign o_cnt     = r_cnt;
  assign o_pending = r_pending;
  assign o_active  = (r_cnt != 32'd0);

endmodule

// File: rtl/riscv_hwloop_regs.sv
// Hardware-loop register file: decodes the ID/CSR write target and
// flattens N_REGSETS independent loop sets onto the output buses.
module riscv_hwloop_regs
  import riscv_hwloop_pkg::*;
#(
  parameter int N_REGSETS = 2,
  parameter int REGSET_W  = regset_w(N_REGSETS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             hwlp_start_data_i,
  input  logic [31:0]             hwlp_end_data_i,
  input  logic [31:0]             hwlp_cnt_data_i,
  input  logic [2:0]              hwlp_we_i,
  input  logic [REGSET_W-1:0]     hwlp_regid_i,
  input  logic [N_REGSETS-1:0]    hwlp_dec_cnt_i,
  input  logic                    id_valid_i,
  input  logic                    flush_i,
  output logic [32*N_REGSETS-1:0] hwlp_start_addr_o,
  output logic [32*N_REGSETS-1:0] hwlp_end_addr_o,
  output logic [32*N_REGSETS-1:0] hwlp_counter_o,
  output logic [N_REGSETS-1:0]    hwlp_dec_cnt_id_o,
  output logic [N_REGSETS-1:0]    hwlp_active_o
);

  for (genvar k = 0; k < N_REGSETS; k++) begin : g_set
    logic w_sel;

    // Out-of-range ids match no set, so such writes fall on the floor.
    assign w_sel = (hwlp_regid_i == REGSET_W'(k));

    riscv_hwloop_regset u_set (
      .clk          (clk),
      .rst          (rst),
      .i_we_start   (w_sel && hwlp_we_i[HWLP_WE_START]),
      .i_we_end     (w_sel && hwlp_we_i[HWLP_WE_END]),
      .i_we_cnt     (w_sel && hwlp_we_i[HWLP_WE_CNT]),
      .i_start_data (hwlp_start_data_i),
      .i_end_data   (hwlp_end_data_i),
      .i_cnt_data   (hwlp_cnt_data_i),
      .i_dec_issue  (hwlp_dec_cnt_i[k]),
      .i_id_valid   (id_valid_i),
      .i_flush      (flush_i),
      .o_start      (hwlp_start_addr_o[32*k +: 32]),
      .o_end        (hwlp_end_addr_o[32*k +: 32]),
      .o_cnt        (hwlp_counter_o[32*k +: 32]),
      .o_pending    (hwlp_dec_cnt_id_o[k]),
      .o_active     (hwlp_active_o[k])
    );
  end

endmodule

// File: tb/tb_riscv_hwloop_regs.sv
// Directed bench for riscv_hwloop_regs: a 2-set instance for the main
// behaviour and a 3-set instance for out-of-range register ids.
module tb_riscv_hwloop_regs;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] start_d, end_d, cnt_d;
  logic [2:0]  we;
  logic [0:0]  regid;
  logic [1:0]  dec;
  logic        id_valid, flush;
  logic [63:0] start_o, end_o, cnt_o;
  logic [1:0]  dec_id_o, active_o;

  logic [2:0]  we3;
  logic [1:0]  regid3;
  logic [95:0] start3_o, end3_o, cnt3_o;
  logic [2:0]  dec_id3_o, active3_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  riscv_hwloop_regs #(.N_REGSETS(2)) dut (
    .clk(clk), .rst(rst),
    .hwlp_start_data_i(start_d), .hwlp_end_data_i(end_d), .hwlp_cnt_data_i(cnt_d),
    .hwlp_we_i(we), .hwlp_regid_i(regid), .hwlp_dec_cnt_i(dec),
    .id_valid_i(id_valid), .flush_i(flush),
    .hwlp_start_addr_o(start_o), .hwlp_end_addr_o(end_o), .hwlp_counter_o(cnt_o),
    .hwlp_dec_cnt_id_o(dec_id_o), .hwlp_active_o(active_o)
  );

  riscv_hwloop_regs #(.N_REGSETS(3)) dut3 (
    .clk(clk), .rst(rst),
    .hwlp_start_data_i(start_d), .hwlp_end_data_i(end_d), .hwlp_cnt_data_i(cnt_d),
    .hwlp_we_i(we3), .hwlp_regid_i(regid3), .hwlp_dec_cnt_i(3'b000),
    .id_valid_i(1'b0), .flush_i(1'b0),
    .hwlp_start_addr_o(start3_o), .hwlp_end_addr_o(end3_o), .hwlp_counter_o(cnt3_o),
    .hwlp_dec_cnt_id_o(dec_id3_o), .hwlp_active_o(active3_o)
  );

  always @(posedge clk)
    if (!rst) assert ($onehot0(dec)) else $error("dec_cnt_i not one-hot: %b", dec);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [95:0] got, input logic [95:0] exp);
    // intentionally unused helper avoided; comparisons are inline in each test
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (cnt_o !== 64'd0 || dec_id_o !== 2'b00 || active_o !== 2'b00) begin
      failures++;
      $display("FAIL reset_initial got cnt=%h pend=%b act=%b exp 0", cnt_o, dec_id_o, active_o);
    end
    @(negedge clk); rst = 1'b0;
    tick();
    we = 3'b100; regid = 1'b0; cnt_d = 32'd5;
    tick();
    we = 3'b000; dec = 2'b01;
    tick();
    dec = 2'b00;
    checks++;
    if (cnt_o[31:0] !== 32'd5 || dec_id_o !== 2'b01) begin
      failures++;
      $display("FAIL reset_precond got cnt0=%h pend=%b exp 5 01", cnt_o[31:0], dec_id_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (cnt_o !== 64'd0 || start_o !== 64'd0 || end_o !== 64'd0 ||
        dec_id_o !== 2'b00 || active_o !== 2'b00) begin
      failures++;
      $display("FAIL reset_async got cnt=%h pend=%b act=%b exp all 0", cnt_o, dec_id_o, active_o);
    end
    @(negedge clk); rst = 1'b0;
    tick();
  endtask

  task automatic test_setup();
    we = 3'b111; regid = 1'b1;
    start_d = 32'h100; end_d = 32'h120; cnt_d = 32'd3;
    tick();
    we = 3'b000;
    checks++;
    if (start_o[63:32] !== 32'h100 || end_o[63:32] !== 32'h120 ||
        cnt_o[63:32] !== 32'd3 || active_o !== 2'b10) begin
      failures++;
      $display("FAIL setup_set1 got s=%h e=%h c=%h act=%b exp 100 120 3 10",
               start_o[63:32], end_o[63:32], cnt_o[63:32], active_o);
    end
    checks++;
    if (start_o[31:0] !== 32'd0 || end_o[31:0] !== 32'd0 || cnt_o[31:0] !== 32'd0) begin
      failures++;
      $display("FAIL setup_set0 got s=%h e=%h c=%h exp 0", start_o[31:0], end_o[31:0], cnt_o[31:0]);
    end
  endtask

  task automatic test_issue_commit();
    dec = 2'b10;
    tick();
    dec = 2'b00; id_valid = 1'b1;
    checks++;
    if (dec_id_o !== 2'b10 || cnt_o[63:32] !== 32'd3) begin
      failures++;
      $display("FAIL issue_pending got pend=%b c1=%h exp 10 3", dec_id_o, cnt_o[63:32]);
    end
    tick();
    id_valid = 1'b0;
    checks++;
    if (dec_id_o !== 2'b00 || cnt_o[63:32] !== 32'd2) begin
      failures++;
      $display("FAIL commit got pend=%b c1=%h exp 00 2", dec_id_o, cnt_o[63:32]);
    end
  endtask

  task automatic test_stall_flush();
    we = 3'b100; regid = 1'b1; cnt_d = 32'd3;
    tick();
    we = 3'b000; dec = 2'b10;
    tick();
    dec = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (dec_id_o !== 2'b10 || cnt_o[63:32] !== 32'd3) begin
        failures++;
        $display("FAIL stall_%0d got pend=%b c1=%h exp 10 3", i, dec_id_o, cnt_o[63:32]);
      end
    end
    flush = 1'b1; id_valid = 1'b1;
    tick();
    flush = 1'b0; id_valid = 1'b0;
    checks++;
    if (dec_id_o !== 2'b00 || cnt_o[63:32] !== 32'd3) begin
      failures++;
      $display("FAIL flush got pend=%b c1=%h exp 00 3", dec_id_o, cnt_o[63:32]);
    end
    dec = 2'b10; flush = 1'b1;
    tick();
    dec = 2'b00; flush = 1'b0;
    checks++;
    if (dec_id_o !== 2'b00) begin
      failures++;
      $display("FAIL flush_issue got pend=%b exp 00", dec_id_o);
    end
  endtask

  task automatic test_collision();
    dec = 2'b10;
    tick();
    dec = 2'b00; id_valid = 1'b1; we = 3'b100; regid = 1'b1; cnt_d = 32'd7;
    tick();
    we = 3'b000; id_valid = 1'b0;
    checks++;
    if (cnt_o[63:32] !== 32'd7 || dec_id_o !== 2'b00) begin
      failures++;
      $display("FAIL write_vs_commit got c1=%h pend=%b exp 7 00", cnt_o[63:32], dec_id_o);
    end
    // Re-issue while committing keeps the pending bit set.
    dec = 2'b10;
    tick();
    id_valid = 1'b1;
    tick();
    dec = 2'b00;
    checks++;
    if (cnt_o[63:32] !== 32'd6 || dec_id_o !== 2'b10) begin
      failures++;
      $display("FAIL issue_priority got c1=%h pend=%b exp 6 10", cnt_o[63:32], dec_id_o);
    end
    tick();
    id_valid = 1'b0;
    checks++;
    if (cnt_o[63:32] !== 32'd5 || dec_id_o !== 2'b00) begin
      failures++;
      $display("FAIL back_to_back got c1=%h pend=%b exp 5 00", cnt_o[63:32], dec_id_o);
    end
  endtask

  task automatic test_floor();
    dec = 2'b01;
    tick();
    dec = 2'b00; id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    checks++;
    if (cnt_o[31:0] !== 32'd0 || active_o[0] !== 1'b0 || dec_id_o[0] !== 1'b0) begin
      failures++;
      $display("FAIL floor got c0=%h act0=%b pend0=%b exp 0 0 0", cnt_o[31:0], active_o[0], dec_id_o[0]);
    end
  endtask

  task automatic test_addr_write();
    dec = 2'b10;
    tick();
    dec = 2'b00; we = 3'b011; regid = 1'b1; start_d = 32'hDEAD_BEE3; end_d = 32'h0000_0201;
    tick();
    we = 3'b000;
    checks++;
    if (start_o[63:32] !== 32'hDEAD_BEE3 || end_o[63:32] !== 32'h0000_0201 ||
        cnt_o[63:32] !== 32'd5 || dec_id_o !== 2'b10) begin
      failures++;
      $display("FAIL addr_write got s=%h e=%h c1=%h pend=%b exp deadbee3 201 5 10",
               start_o[63:32], end_o[63:32], cnt_o[63:32], dec_id_o);
    end
    id_valid = 1'b1;
    tick();
    id_valid = 1'b0;
    checks++;
    if (cnt_o[63:32] !== 32'd4 || dec_id_o !== 2'b00) begin
      failures++;
      $display("FAIL addr_commit got c1=%h pend=%b exp 4 00", cnt_o[63:32], dec_id_o);
    end
  endtask

  task automatic test_out_of_range();
    we3 = 3'b111; regid3 = 2'd2; start_d = 32'h300; end_d = 32'h340; cnt_d = 32'd9;
    tick();
    checks++;
    if (start3_o[95:64] !== 32'h300 || cnt3_o[95:64] !== 32'd9 || active3_o !== 3'b100) begin
      failures++;
      $display("FAIL set2_write got s=%h c=%h act=%b exp 300 9 100",
               start3_o[95:64], cnt3_o[95:64], active3_o);
    end
    regid3 = 2'd3; start_d = 32'hAAAA_0000; end_d = 32'hBBBB_0000; cnt_d = 32'd77;
    tick();
    we3 = 3'b000;
    checks++;
    if (start3_o !== {32'h300, 64'd0} || end3_o !== {32'h340, 64'd0} ||
        cnt3_o !== {32'd9, 64'd0}) begin
      failures++;
      $display("FAIL regid_oob got s=%h e=%h c=%h", start3_o, end3_o, cnt3_o);
    end
  endtask

  initial begin
    rst = 1'b1; start_d = '0; end_d = '0; cnt_d = '0; we = '0; regid = '0;
    dec = '0; id_valid = 1'b0; flush = 1'b0; we3 = '0; regid3 = '0;
    test_reset();
    test_setup();
    test_issue_commit();
    test_stall_flush();
    test_collision();
    test_floor();
    test_addr_write();
    test_out_of_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/riscv_hwloop_regs.md
Name: riscv_hwloop_regs

Overview:
- Hardware-loop register file for RI5CY: holds start address, end address and iteration counter for N_REGSETS loop sets.
- Feeds the hwloop controller, and consumes its per-set decrement requests as a two-phase (issue/commit) pipeline, so the controller can see decrements still in flight.
- Written by the ID stage (lp.setup/lp.start/lp.end/lp.count) and by CSR accesses.

Parameters:
N_REGSETS, 2, number of loop register sets (1..4); set index width REGSET_W = clog2(N_REGSETS), minimum 1.

Ports:
clk  in  1  core clock
rst  in  1  asynchronous reset, active-high
hwlp_start_data_i  in  32  start address write data
hwlp_end_data_i  in  32  end address write data
hwlp_cnt_data_i  in  32  counter write data
hwlp_we_i  in  3  write enables: [0] start, [1] end, [2] counter
hwlp_regid_i  in  REGSET_W  target set for writes
hwlp_dec_cnt_i  in  N_REGSETS  one-hot decrement issue from controller (IF-time)
id_valid_i  in  1  instruction in ID advances this cycle
flush_i  in  1  kill IF/ID contents (branch, exception)
hwlp_start_addr_o  out  32*N_REGSETS  start addresses, set k at [32k+31:32k]
hwlp_end_addr_o  out  32*N_REGSETS  end addresses
hwlp_counter_o  out  32*N_REGSETS  counters
hwlp_dec_cnt_id_o  out  N_REGSETS  decrement pending (issued, not committed)
hwlp_active_o  out  N_REGSETS  counter of set k is non-zero

Behaviour:
- Reset (async, rst=1): all start, end and counter registers = 0; pending = 0; hwlp_active_o = 0.
- Outputs are direct register values; no combinational path from inputs to outputs except hwlp_active_o, which is derived from the counter register.
- Writes:
  - On a clk rising edge, for each we bit set, the selected field of set hwlp_regid_i takes its data input.
  - Any combination of the three bits may be set in one cycle; lp.setup uses all three.
  - hwlp_regid_i >= N_REGSETS: write ignored.
- Decrement issue:
  - pending[k] is set on the edge where hwlp_dec_cnt_i[k]=1.
  - hwlp_dec_cnt_id_o = pending, a registered copy; it is high the cycle after issue.
- Decrement commit:
  - If pending[k]=1 and id_valid_i=1, then counter[k] <= counter[k]-1 and pending[k] clears.
  - A new issue in the same cycle keeps pending[k]=1 (set has priority over clear).
- Pending hold: if pending[k]=1 and id_valid_i=0, pending[k] holds (stall).
- Flush: flush_i=1 clears all pending bits with no counter change. A same-cycle issue is also discarded.
- Counter floor: a decrement is never applied when counter[k]==0; the counter stays 0 and no wrap to 0xFFFFFFFF occurs.
- Write vs commit on the same set in the same cycle: the counter write wins, the decrement is dropped, and pending[k] clears.
- Start/end writes never affect pending or counter.
- At most one bit of hwlp_dec_cnt_i is set per cycle (controller guarantee). The bench checks this with an assertion; the RTL handles any pattern per bit independently.
- Addresses are stored as 32 bits exactly as written; no alignment masking.
- Counter arithmetic is unsigned 32-bit.

Decomposition:
- Shared package riscv_hwloop_pkg holds:
  - the we bit indices HWLP_WE_START=0, HWLP_WE_END=1, HWLP_WE_CNT=2;
  - the constant HWLP_MAX_REGSETS=4;
  - REGSET_W computation as a function.
- One natural sub-module, riscv_hwloop_regset: a single set's start/end/counter registers plus its pending bit and commit/flush logic. Instantiated N_REGSETS times in a generate loop; the top does regid decode and output concatenation.

Test Plan:
1. Reset: assert rst mid-run with counter[0]=5 and pending[0]=1 -> next sampled outputs are all 0 and hwlp_dec_cnt_id_o=0, independent of clk.
2. Setup: we=3'b111, regid=1, data start=0x100, end=0x120, cnt=3 -> next cycle set1 start=0x100, end=0x120, counter=3, active_o=2'b10; set0 unchanged.
3. Issue/commit: dec_cnt_i=2'b10 at cycle t, id_valid_i=1 at t+1 -> dec_cnt_id_o[1]=1 during t+1, counter[1]=2 at t+2, pending cleared.
4. Stall/flush:
   - issue with id_valid_i=0 for 3 cycles -> counter holds 3 and pending stays 1;
   - then flush_i=1 -> pending=0 and counter still 3.
5. Collision and floor:
   - counter write (cnt=7) on the same cycle as a commit to that set -> counter=7, pending=0;
   - separately, a commit with counter=0 -> counter stays 0 and active_o stays 0.
6. Out-of-range regid with N_REGSETS=3, regid=3, we=3'b111 -> no register changes in any set.
